// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam int MULT_W_DEFAULT = 32;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int count_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_abs.sv
// rtl/mult_abs.sv - operand conditioning: magnitude and sign of a signed/unsigned value
module mult_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             neg_o
);

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign neg_o = signed_i & value_i[WIDTH-1];
    assign mag_o = neg_o ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - multi-cycle shift-add multiplier with start/done handshake
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   mplr_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               ovf_o
);

    localparam int CW = count_w(WIDTH);

    mult_state_t        state;
    mult_state_t        next_state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_q;
    logic               signed_q;
    logic [CW-1:0]      count;
    logic               count_end;

    logic [WIDTH-1:0]   mplr_mag;
    logic [WIDTH-1:0]   mcand_mag;
    logic               mplr_neg;
    logic               mcand_neg;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     prod_hi;
    logic               ovf_next;

    mult_abs #(.WIDTH(WIDTH)) u_abs_mplr (
        .value_i  (mplr_i),
        .signed_i (signed_i),
        .mag_o    (mplr_mag),
        .neg_o    (mplr_neg)
    );

    mult_abs #(.WIDTH(WIDTH)) u_abs_mcand (
        .value_i  (mcand_i),
        .signed_i (signed_i),
        .mag_o    (mcand_mag),
        .neg_o    (mcand_neg)
    );

    assign count_end = (count == CW'(WIDTH));

    // Carry out of the upper-half add is shifted back in as the new MSB.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign acc_step = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    assign prod_next = neg_q ? -acc : acc;
    assign prod_hi   = prod_next[2*WIDTH-1:WIDTH-1];
    assign ovf_next  = signed_q ? !((&prod_hi) || !(|prod_hi))
                                : (|prod_next[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_i) next_state = RUN;
            RUN:  if (count_end) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        done_o = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
            count    <= '0;
            prod_o   <= '0;
            ovf_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc      <= {{WIDTH{1'b0}}, mplr_mag};
                        mcand_q  <= mcand_mag;
                        neg_q    <= mplr_neg ^ mcand_neg;
                        signed_q <= signed_i;
                        count    <= '0;
                    end
                end
                RUN: begin
                    if (!count_end) begin
                        acc   <= acc_step;
                        count <= count + CW'(1);
                    end
                end
                FIX: begin
                    prod_o <= prod_next;
                    ovf_o  <= ovf_next;
                end
                default: ;
            endcase
        end
    end

endmodule
